// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and receiver. It holds the FSM
// state encodings, the number of data bits per frame and the bit-period clamp.
// The state encodings are plain localparam constants so older code that
// compares raw state values keeps working.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_START_BIT  = 3'd1;
  localparam state_t ST_SEND_DATA  = 3'd2;
  localparam state_t ST_PARITY_BIT = 3'd3;
  localparam state_t ST_STOP_BIT   = 3'd4;

  // A divider of 0 or 1 both mean one clock per bit, so the bit counter
  // always has a non-zero period.
  function automatic logic [31:0] bit_len(input logic [31:0] clk_div);
    return (clk_div < 32'd2) ? 32'd1 : clk_div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO that buffers bytes for the UART transmitter.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   flush        empties the FIFO on the next edge, the same as rst
//   push, din    write request and its data
//   pop          read request; dout always shows the head entry
//   full, empty  occupancy flags, derived from the registered count
//   count        number of stored entries
//   count_next   the value count takes at the next edge, so the parent can
//                register status that must agree with count
// A push while full is accepted only when a pop happens in the same cycle.
// FIFO_DEPTH must be a power of two so the pointers wrap for free.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [$clog2(FIFO_DEPTH):0]   count_next
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next occupancy; a flush wins over any push or pop in the same cycle.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage needs no reset; entries are only read once they have been written.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_transmit.sv
// uart_transmit
// UART transmitter. Bytes are queued in a small FIFO and sent LSB-first on tx
// as 8N1 frames. When the macro UART_TX_PARITY_EN is defined, the frames are
// 8E1 instead: an even parity bit goes between data bit 7 and the stop bit.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   clk_div    clock cycles per bit (0 and 1 both mean 1); shared with the receiver
//   wr         write strobe, queues tx_data
//   tx_data    byte to queue
//   irq_en     enables the transmit-done interrupt
//   tx         serial line, idles high
//   full       FIFO full; a write while full is dropped unless a pop happens the same cycle
//   busy       a frame is on the line or bytes are still queued
//   irq        level interrupt: enabled, idle and nothing left to send
module uart_transmit
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clk_div,
  input  logic        wr,
  input  logic [7:0]  tx_data,
  input  logic        irq_en,
  output logic        tx,
  output logic        full,
  output logic        busy,
  output logic        irq
);

  state_t                   state, state_n;
  logic                     tx_n;
  logic [31:0]              clk_cnt, clk_cnt_n;
  logic [2:0]               bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]     shift_reg, shift_n;
  logic                     bit_end;
  logic                     pop;
  logic                     flush;
  logic [DATA_BITS-1:0]     fifo_dout;
  logic                     fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_next;
`ifdef UART_TX_PARITY_EN
  logic                     parity_reg, parity_n;
`endif

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (wr),
    .pop        (pop),
    .din        (tx_data),
    .dout       (fifo_dout),
    .full       (full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  // The comparison uses >= so that lowering clk_div in the middle of a bit
  // ends that bit at the next edge rather than letting the counter run away.
  assign bit_end = (clk_cnt >= (bit_len(clk_div) - 32'd1));

  // Next-state logic for the framer. tx is registered, so each assignment to
  // tx_n here is the line level for the bit that starts at the next edge.
  // Loading a byte happens both from IDLE and directly out of the stop bit,
  // which is what makes back-to-back frames gap-free.
  always_comb begin
    state_n   = state;
    tx_n      = tx;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    pop       = 1'b0;
    flush     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n  = parity_reg;
`endif

    if (state != ST_IDLE) begin
      clk_cnt_n = bit_end ? 32'd0 : clk_cnt + 32'd1;
    end

    case (state)
      ST_IDLE: begin
        clk_cnt_n = 32'd0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_n   = fifo_dout;
          bit_idx_n = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_n  = ^fifo_dout;
`endif
          tx_n      = 1'b0;
          state_n   = ST_START_BIT;
        end
      end

      ST_START_BIT: begin
        if (bit_end) begin
          tx_n      = shift_reg[0];
          shift_n   = {1'b0, shift_reg[DATA_BITS-1:1]};
          bit_idx_n = 3'd0;
          state_n   = ST_SEND_DATA;
        end
      end

      ST_SEND_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_n    = parity_reg;
            state_n = ST_PARITY_BIT;
`else
            tx_n    = 1'b1;
            state_n = ST_STOP_BIT;
`endif
          end else begin
            tx_n      = shift_reg[0];
            shift_n   = {1'b0, shift_reg[DATA_BITS-1:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY_BIT: begin
        if (bit_end) begin
          tx_n    = 1'b1;
          state_n = ST_STOP_BIT;
        end
      end
`endif

      ST_STOP_BIT: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_n   = fifo_dout;
            bit_idx_n = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_n  = ^fifo_dout;
`endif
            tx_n      = 1'b0;
            state_n   = ST_START_BIT;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end

      // An unknown encoding recovers exactly as a reset would, FIFO included.
      default: begin
        flush     = 1'b1;
        tx_n      = 1'b1;
        clk_cnt_n = 32'd0;
        bit_idx_n = 3'd0;
        state_n   = ST_IDLE;
      end
    endcase
  end

  // Framer registers. busy is built from the next state and next FIFO count
  // so that, once registered, it always agrees with state and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      clk_cnt   <= 32'd0;
      bit_idx   <= 3'd0;
      shift_reg <= '0;
      busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tx        <= tx_n;
      clk_cnt   <= clk_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      busy      <= (state_n != ST_IDLE) || (fifo_count_next != '0);
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_n;
`endif
    end
  end

  // Transmit-done interrupt. A write clears it on the following cycle even
  // before the byte is visible in the FIFO count.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && !wr && (state == ST_IDLE) && (fifo_count == '0);
    end
  end

endmodule
